// File: rtl/y_buf_reader_if.sv
// Result-buffer write port plus the ready/valid read stream of y_buf_reader.
// The slave modport is the reader block; master is whoever writes results and consumes the stream.
interface y_buf_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic                  y_buf_en;
  logic                  y_buf_wr_en;
  logic [ADDR_WIDTH-1:0] y_buf_addr;
  logic [DATA_WIDTH-1:0] y_buf_data;
  logic                  rd_valid_o;
  logic                  rd_ready_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic [3:0]            rd_idx_o;
  logic                  rd_last_o;

  modport master (
    output y_buf_en, y_buf_wr_en, y_buf_addr, y_buf_data, rd_ready_i,
    input  rd_valid_o, rd_data_o, rd_idx_o, rd_last_o
  );

  modport slave (
    input  y_buf_en, y_buf_wr_en, y_buf_addr, y_buf_data, rd_ready_i,
    output rd_valid_o, rd_data_o, rd_idx_o, rd_last_o
  );
endinterface

// File: rtl/y_buf_reader.sv
// Captures the FP32 class scores, finds the argmax with one compare per cycle,
// then streams the scores out over ready/valid.
module y_buf_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUT    = 10,
  parameter int ADDR_WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               done_i,
  y_buf_reader_if.slave      bus,
  output logic [3:0]         argmax_o,
  output logic               argmax_valid_o,
  output logic [NUM_OUT-1:0] wr_mask_o,
  output logic               err_o
);
  typedef enum logic [1:0] {IDLE, SCAN, STREAM, DONE} state_t;
  localparam int IW = ADDR_WIDTH - 2;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] mem_q [NUM_OUT];
  logic [NUM_OUT-1:0]    mask_q;
  logic                  err_q;
  logic [3:0]            cnt_q;
  logic [3:0]            best_idx_q;
  logic [DATA_WIDTH-1:0] best_key_q;
  logic [3:0]            argmax_q;
  logic                  av_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [3:0]            rd_idx_q;
  logic                  rd_last_q;

  logic                  wr_req;
  logic                  wr_ok;
  logic [IW-1:0]         widx;
  logic [DATA_WIDTH-1:0] scan_word;
  logic [DATA_WIDTH-1:0] scan_key;
  logic [DATA_WIDTH-1:0] nxt_word;
  logic [3:0]            rd_idx_d;
  logic                  xfer;

  // Maps FP32 onto an unsigned key whose ordering matches the float ordering (-0 < +0).
  function automatic logic [DATA_WIDTH-1:0] fkey(input logic [DATA_WIDTH-1:0] w);
    return w[DATA_WIDTH-1] ? {1'b0, ~w[DATA_WIDTH-2:0]} : {1'b1, w[DATA_WIDTH-2:0]};
  endfunction

  always_comb begin
    wr_req    = bus.y_buf_en & bus.y_buf_wr_en;
    widx      = bus.y_buf_addr[ADDR_WIDTH-1:2];
    wr_ok     = wr_req && (bus.y_buf_addr[1:0] == 2'b00) && (32'(widx) < 32'(NUM_OUT));
    rd_idx_d  = rd_idx_q + 4'd1;
    xfer      = rd_valid_q & bus.rd_ready_i;
    scan_word = '0;
    nxt_word  = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (32'(cnt_q) == i)    scan_word = mem_q[i];
      if (32'(rd_idx_d) == i) nxt_word  = mem_q[i];
    end
    scan_key = fkey(scan_word);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_q      <= '{default: '0};
      mask_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      best_idx_q <= '0;
      best_key_q <= '0;
      argmax_q   <= '0;
      av_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
      rd_last_q  <= 1'b0;
    end else if (start_i) begin
      state_q    <= IDLE;
      mem_q      <= '{default: '0};
      mask_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      best_idx_q <= '0;
      best_key_q <= '0;
      argmax_q   <= '0;
      av_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      if (wr_req && (state_q != IDLE || !wr_ok)) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (wr_ok && 32'(widx) == i) begin
              mem_q[i]  <= bus.y_buf_data;
              mask_q[i] <= 1'b1;
            end
          end
          if (done_i) begin
            state_q <= SCAN;
            cnt_q   <= '0;
          end
        end
        // Counter runs one step past the last entry so the final compare lands
        // in best_*_q before it is published.
        SCAN: begin
          if (cnt_q == 4'(NUM_OUT)) begin
            state_q    <= STREAM;
            cnt_q      <= '0;
            argmax_q   <= best_idx_q;
            av_q       <= 1'b1;
            rd_valid_q <= 1'b1;
            rd_idx_q   <= '0;
            rd_data_q  <= mem_q[0];
            rd_last_q  <= (NUM_OUT == 1);
          end else begin
            if (cnt_q == '0 || scan_key > best_key_q) begin
              best_key_q <= scan_key;
              best_idx_q <= cnt_q;
            end
            cnt_q <= cnt_q + 4'd1;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (rd_last_q) begin
              state_q    <= DONE;
              rd_valid_q <= 1'b0;
            end else begin
              rd_idx_q  <= rd_idx_d;
              rd_data_q <= nxt_word;
              rd_last_q <= (rd_idx_d == 4'(NUM_OUT - 1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_data_o  = rd_data_q;
  assign bus.rd_idx_o   = rd_idx_q;
  assign bus.rd_last_o  = rd_last_q;
  assign argmax_o       = argmax_q;
  assign argmax_valid_o = av_q;
  assign wr_mask_o      = mask_q;
  assign err_o          = err_q;
endmodule

// File: tb/tb_y_buf_reader.sv
// Scoreboard bench for y_buf_reader: stimulus pushes expected stream words and
// argmax results; negedge monitors pop and compare as the DUT presents them.
module tb_y_buf_reader;
  localparam int DW = 32;
  localparam int NO = 10;
  localparam int AW = 6;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  i;
    logic        l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          done = 1'b0;
  logic [3:0]    argmax;
  logic          argmax_valid;
  logic [NO-1:0] wr_mask;
  logic          err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cyc = 0;
  bit rand_rdy = 1'b0;
  bit fix_rdy = 1'b0;
  bit av_prev = 1'b0;

  exp_t        exp_q[$];
  logic [3:0]  am_q[$];
  logic [31:0] img [NO];

  y_buf_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  y_buf_reader #(.DATA_WIDTH(DW), .NUM_OUT(NO), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .done_i(done), .bus(bus),
    .argmax_o(argmax), .argmax_valid_o(argmax_valid), .wr_mask_o(wr_mask), .err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.rd_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.rd_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : fix_rdy;
    end
  end

  // Stream monitor: the head of the queue must be on the bus for every valid cycle,
  // and is retired only on an accepted transfer.
  always @(negedge clk) begin
    if (rst_n && bus.rd_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_extra got d=%h i=%0d want no word", bus.rd_data_o, bus.rd_idx_o);
      end else begin
        if ({bus.rd_data_o, bus.rd_idx_o, bus.rd_last_o} !== exp_q[0]) begin
          errors++;
          $display("FAIL stream_word got d=%h i=%0d l=%b want d=%h i=%0d l=%b",
                   bus.rd_data_o, bus.rd_idx_o, bus.rd_last_o, exp_q[0].d, exp_q[0].i, exp_q[0].l);
        end
        if (bus.rd_ready_i) void'(exp_q.pop_front());
      end
    end
    if (argmax_valid && !av_prev) begin
      checks++;
      if (am_q.size() == 0) begin
        errors++;
        $display("FAIL argmax_extra got %0d want none", argmax);
      end else begin
        if (argmax !== am_q[0] || (cyc - done_cyc) != 11) begin
          errors++;
          $display("FAIL argmax got idx=%0d lat=%0d want idx=%0d lat=11",
                   argmax, cyc - done_cyc, am_q[0]);
        end
        void'(am_q.pop_front());
      end
    end
    av_prev = argmax_valid;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [31:0] d);
    bus.y_buf_en = 1'b1; bus.y_buf_wr_en = 1'b1;
    bus.y_buf_addr = AW'(addr); bus.y_buf_data = d;
    @(posedge clk); #1;
    bus.y_buf_en = 1'b0; bus.y_buf_wr_en = 1'b0;
  endtask

  task automatic load_img(input bit with_done);
    for (int i = 0; i < NO; i++) begin
      if (with_done && i == NO - 1) done = 1'b1;
      wr(i * 4, img[i]);
    end
    if (with_done) begin
      done_cyc = cyc;
      done = 1'b0;
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(posedge clk); #1;
    done_cyc = cyc;
    done = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic expect_run(input logic [3:0] am);
    for (int i = 0; i < NO; i++) exp_q.push_back({img[i], 4'(i), 1'(i == NO - 1)});
    am_q.push_back(am);
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || am_q.size() != 0 || bus.rd_valid_o) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_timeout got pending=%0d want 0", nm, exp_q.size() + am_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got running want finished");
    $fatal(1);
  end

  initial begin
    int n;
    bus.y_buf_en = 1'b0; bus.y_buf_wr_en = 1'b0; bus.y_buf_addr = '0; bus.y_buf_data = '0;
    #12;
    chk("rst_outputs", {wr_mask, err, argmax, argmax_valid, bus.rd_valid_o, bus.rd_idx_o, bus.rd_last_o}, '0);
    chk("rst_rd_data", bus.rd_data_o, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // A: single peak at entry 7, always ready
    fix_rdy = 1'b1;
    for (int i = 0; i < NO; i++) img[i] = (i == 7) ? 32'h40A00000 : 32'h3F800000;
    load_img(1'b0);
    chk("A_mask", wr_mask, 10'h3FF);
    chk("A_err", err, 1'b0);
    expect_run(4'd7);
    pulse_done();
    wait_drain("A");
    chk("A_done_valid_low", bus.rd_valid_o, 1'b0);
    chk("A_argmax_held", {argmax_valid, argmax}, {1'b1, 4'd7});
    pulse_start();
    chk("A_start_clear", {wr_mask, argmax_valid, argmax, err}, '0);

    // B: tie keeps lower index; illegal writes dropped
    for (int i = 0; i < NO; i++) img[i] = (i == 2 || i == 5) ? 32'h41200000 : 32'hBF800000;
    load_img(1'b0);
    wr(6, 32'h7F000000);
    chk("B_err_misaligned", err, 1'b1);
    wr(40, 32'h7F000000);
    chk("B_mask_kept", wr_mask, 10'h3FF);
    rand_rdy = 1'b1;
    expect_run(4'd2);
    pulse_done();
    wait_drain("B");
    rand_rdy = 1'b0;
    pulse_start();

    // C: +0 beats -0; write during STREAM flagged and ignored
    fix_rdy = 1'b0;
    for (int i = 0; i < NO; i++) img[i] = 32'hC0000000;
    img[0] = 32'h80000000;
    img[1] = 32'h00000000;
    load_img(1'b0);
    chk("C_err_clean", err, 1'b0);
    expect_run(4'd1);
    pulse_done();
    n = 0;
    while (!bus.rd_valid_o && n < 50) begin @(posedge clk); #1; n++; end
    chk("C_valid_seen", bus.rd_valid_o, 1'b1);
    wr(36, 32'h12345678);
    chk("C_err_stream_wr", err, 1'b1);
    rand_rdy = 1'b1;
    wait_drain("C");
    rand_rdy = 1'b0;
    fix_rdy = 1'b1;
    pulse_start();

    // D: reset while SCAN counter is 4
    for (int i = 0; i < NO; i++) img[i] = 32'h3F800000 + 32'(i);
    load_img(1'b0);
    wr(2, 32'h0);
    pulse_done();
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("D_rst_outputs", {wr_mask, err, argmax, argmax_valid, bus.rd_valid_o, bus.rd_idx_o, bus.rd_last_o}, '0);
    chk("D_rst_rd_data", bus.rd_data_o, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("D_no_resume", {bus.rd_valid_o, argmax_valid}, 2'b00);

    // E: last write shares the done cycle and must be scanned
    for (int i = 0; i < NO; i++) img[i] = 32'h40000000 | (32'(i) << 20);
    expect_run(4'd9);
    load_img(1'b1);
    wait_drain("E");
    chk("E_argmax_held", {argmax_valid, argmax}, {1'b1, 4'd9});
    pulse_start();
    chk("E_start_in_done", {wr_mask, argmax_valid, bus.rd_valid_o}, '0);

    // F: start beats a same-cycle done and write
    start = 1'b1;
    done = 1'b1;
    wr(0, 32'h3F800000);
    start = 1'b0;
    done = 1'b0;
    chk("F_mask_zero", wr_mask, '0);
    repeat (15) @(posedge clk);
    #1;
    chk("F_no_scan", {bus.rd_valid_o, argmax_valid, err}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
